// File: rtl/tx.sv
// Pulse-width IR frame transmitter: sync burst/silence, WIDTH data bits MSB first, stop burst, gap.
// Optional carrier modulation of signal_out is enabled by defining TX_CARRIER_EN.
module tx #(
  parameter int SBD            = 800,
  parameter int SSD            = 800,
  parameter int BBD            = 400,
  parameter int BSD0           = 200,
  parameter int BSD1           = 400,
  parameter int WIDTH          = 8,
  parameter int CARRIER_PERIOD = 2586
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             trigger_in,
  output logic             signal_out,
  output logic             env_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [2:0]       state_out
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC_H = 3'd1,
    SYNC_L = 3'd2,
    BIT_H  = 3'd3,
    BIT_L  = 3'd4,
    STOP_H = 3'd5,
    GAP    = 3'd6
  } state_t;

  // The carrier splits its period into equal high and low halves.
  if ((CARRIER_PERIOD % 2) != 0 || CARRIER_PERIOD < 2) begin : g_bad_carrier
    $error("tx: CARRIER_PERIOD must be even and at least 2");
  end

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic              env_q, env_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              signal_q, signal_d;
  logic [31:0]       dur;
  logic              lastCycle;

  always_comb begin
    dur = 32'd0;
    case (state_q)
      SYNC_H:  dur = 32'(SBD);
      SYNC_L:  dur = 32'(SSD);
      BIT_H:   dur = 32'(BBD);
      BIT_L:   dur = data_q[WIDTH-1] ? 32'(BSD1) : 32'(BSD0);
      STOP_H:  dur = 32'(BBD);
      GAP:     dur = 32'(SSD);
      default: dur = 32'd0;
    endcase
    lastCycle = (cnt_q == dur - 32'd1);
  end

  // Next-state logic; every output register is loaded from the next state so it
  // switches on the same edge as the state itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    data_d  = data_q;
    bits_d  = bits_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (trigger_in) begin
          state_d = SYNC_H;
          data_d  = data_in;
          bits_d  = '0;
        end
      end
      SYNC_H: if (lastCycle) state_d = SYNC_L;
      SYNC_L: if (lastCycle) state_d = BIT_H;
      BIT_H:  if (lastCycle) state_d = BIT_L;
      BIT_L: begin
        if (lastCycle) begin
          data_d  = data_q << 1;
          bits_d  = bits_q + BW'(1);
          state_d = (bits_q == BW'(WIDTH - 1)) ? STOP_H : BIT_H;
        end
      end
      STOP_H: if (lastCycle) state_d = GAP;
      GAP: begin
        if (lastCycle) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = 32'd0;
    env_d  = (state_d == SYNC_H) || (state_d == BIT_H) || (state_d == STOP_H);
    busy_d = (state_d != IDLE);
  end

`ifdef TX_CARRIER_EN
  logic [31:0] phase_q, phase_d;

  // Carrier phase restarts on entry to every burst so each burst begins high.
  always_comb begin
    phase_d = phase_q + 32'd1;
    if (env_d && (state_d != state_q)) phase_d = 32'd0;
    else if (phase_q == 32'(CARRIER_PERIOD - 1)) phase_d = 32'd0;
    signal_d = env_d && (phase_d < 32'(CARRIER_PERIOD / 2));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) phase_q <= 32'd0;
    else        phase_q <= phase_d;
  end
`else
  always_comb signal_d = env_d;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      data_q   <= '0;
      bits_q   <= '0;
      env_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      signal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      bits_q   <= bits_d;
      env_q    <= env_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      signal_q <= signal_d;
    end
  end

  assign signal_out = signal_q;
  assign env_out    = env_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_tx.sv
// Randomized scoreboard bench for tx: each accepted frame pushes its expected envelope
// run lengths; a negedge monitor rebuilds the observed runs and compares at frame end.
module tb_tx;

  localparam int P_SBD  = 16;
  localparam int P_SSD  = 12;
  localparam int P_BBD  = 8;
  localparam int P_BSD0 = 4;
  localparam int P_BSD1 = 6;
  localparam int P_W    = 8;
  localparam int P_CP   = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [P_W-1:0] dataIn;
  logic           trigger;
  logic           signalOut, envOut, busyOut, doneOut;
  logic [2:0]     stateOut;

  tx #(
    .SBD(P_SBD), .SSD(P_SSD), .BBD(P_BBD), .BSD0(P_BSD0), .BSD1(P_BSD1),
    .WIDTH(P_W), .CARRIER_PERIOD(P_CP)
  ) dut (
    .clk_in(clk), .rst_in(rst), .data_in(dataIn), .trigger_in(trigger),
    .signal_out(signalOut), .env_out(envOut), .busy_out(busyOut),
    .done_out(doneOut), .state_out(stateOut)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int expCount[$];
  int expSegs[$];
  bit monitorOn = 1'b0;
  bit abortFlag = 1'b0;
  int idleErr = 0;

  task automatic checkOutput(input string name, input longint actual, input longint required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Reference frame: alternating high/low envelope run lengths, starting with the sync burst.
  task automatic pushExpected(input logic [P_W-1:0] d);
    logic [P_W-1:0] w;
    w = d;
    expCount.push_back(4 + 2 * P_W);
    expSegs.push_back(P_SBD);
    expSegs.push_back(P_SSD);
    for (int i = P_W - 1; i >= 0; i--) begin
      expSegs.push_back(P_BBD);
      expSegs.push_back(w[i] ? P_BSD1 : P_BSD0);
    end
    expSegs.push_back(P_BBD);
    expSegs.push_back(P_SSD);
  endtask

  int runs[$];
  int runLen, busyLen, sigErr, doneErr;
  logic curLevel, firstLevel;
  bit prevBusy = 1'b0;

  always @(negedge clk) begin
    if (monitorOn) begin
      if (busyOut === 1'b1) begin
        logic expSig;
        if (!prevBusy) begin
          runs.delete();
          runLen = 0;
          busyLen = 0;
          sigErr = 0;
          doneErr = 0;
          curLevel = envOut;
          firstLevel = envOut;
        end
        busyLen++;
        if (runLen == 0 || envOut === curLevel) runLen++;
        else begin
          runs.push_back(runLen);
          curLevel = envOut;
          runLen = 1;
        end
`ifdef TX_CARRIER_EN
        expSig = envOut && (((runLen - 1) % P_CP) < (P_CP / 2));
`else
        expSig = envOut;
`endif
        if (signalOut !== expSig) sigErr++;
        if (doneOut !== 1'b0) doneErr++;
      end else if (prevBusy) begin
        int n, expTotal, badRun, firstBad;
        runs.push_back(runLen);
        if (expCount.size() == 0) begin
          checkOutput("frameQueued", 0, 1);
        end else begin
          n = expCount.pop_front();
          expTotal = 0;
          badRun = 0;
          firstBad = -1;
          for (int i = 0; i < n; i++) begin
            int s;
            s = expSegs.pop_front();
            expTotal += s;
            if (i >= runs.size() || runs[i] != s) begin
              badRun++;
              if (firstBad < 0) firstBad = i;
            end
          end
          if (abortFlag) begin
            checkOutput("abortDone", doneOut, 0);
            checkOutput("abortState", stateOut, 0);
            checkOutput("abortSignal", signalOut, 0);
            checkOutput("abortEnv", envOut, 0);
          end else begin
            checkOutput("busyLength", busyLen, expTotal);
            checkOutput("runCount", runs.size(), n);
            checkOutput("badRunIndex", firstBad, -1);
            checkOutput("firstEnvLevel", firstLevel, 1);
            checkOutput("signalVsEnv", sigErr, 0);
            checkOutput("doneWhileBusy", doneErr, 0);
            checkOutput("donePulse", doneOut, 1);
            checkOutput("idleState", stateOut, 0);
          end
        end
      end else begin
        if (doneOut !== 1'b0 || envOut !== 1'b0 || signalOut !== 1'b0) idleErr++;
      end
      prevBusy = (busyOut === 1'b1);
    end
  end

  task automatic waitBusyLow(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busyOut === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("frameTimeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [P_W-1:0] d);
    @(posedge clk) #1;
    dataIn = d;
    trigger = 1'b1;
    @(posedge clk) #1;
    trigger = 1'b0;
    dataIn = P_W'($urandom);
    pushExpected(d);
    waitBusyLow(1000);
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [P_W-1:0] d2;
    int idleCycles;
    rst = 1'b1;
    trigger = 1'b1;
    dataIn = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetSignal", signalOut, 0);
    checkOutput("resetEnv", envOut, 0);
    checkOutput("resetBusy", busyOut, 0);
    checkOutput("resetDone", doneOut, 0);
    checkOutput("resetState", stateOut, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    trigger = 1'b0;
    monitorOn = 1'b1;
    @(negedge clk);
    checkOutput("trigDuringReset", busyOut, 0);

    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    for (int i = 0; i < 6; i++) applyStimulus(P_W'($urandom));

    // Trigger held across two frames; data changed mid-frame only affects the next one.
    @(posedge clk) #1;
    dataIn = 8'h5A;
    trigger = 1'b1;
    @(posedge clk) #1;
    pushExpected(8'h5A);
    d2 = P_W'($urandom);
    dataIn = d2;
    waitBusyLow(1000);
    pushExpected(d2);
    idleCycles = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busyOut === 1'b1) break;
      idleCycles++;
    end
    checkOutput("backToBackIdle", idleCycles, 1);
    @(posedge clk) #1;
    trigger = 1'b0;
    dataIn = P_W'($urandom);
    waitBusyLow(1000);
    repeat (3) @(negedge clk);
    checkOutput("noExtraFrame", busyOut, 0);

    // Reset part-way through a frame, with trigger high during the reset cycle.
    @(posedge clk) #1;
    dataIn = 8'h3C;
    trigger = 1'b1;
    @(posedge clk) #1;
    trigger = 1'b0;
    pushExpected(8'h3C);
    repeat (50) @(posedge clk);
    #1;
    abortFlag = 1'b1;
    rst = 1'b1;
    trigger = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    trigger = 1'b0;
    @(negedge clk);
    #1;
    abortFlag = 1'b0;
    @(negedge clk);
    checkOutput("trigIgnoredInReset", busyOut, 0);
    applyStimulus(8'h3C);
    for (int i = 0; i < 3; i++) applyStimulus(P_W'($urandom));

    repeat (4) @(negedge clk);
    checkOutput("leftoverFrames", expCount.size(), 0);
    checkOutput("idleOutputs", idleErr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
